// File: rtl/ext_mem_loader_pkg.sv
// Shared definitions for the external memory loader: command codes, FSM states,
// header size and packing constants.
package ext_mem_loader_pkg;

  localparam logic [2:0] CMD_ACT   = 3'd0;
  localparam logic [2:0] CMD_PARAM = 3'd1;
  localparam logic [2:0] CMD_INST  = 3'd2;
  localparam logic [2:0] CMD_START = 3'd3;
  localparam logic [2:0] CMD_RB    = 3'd4;

  localparam int unsigned HDR_BYTES  = 4;
  // Widest word (parameter memory) sets the packer depth.
  localparam int unsigned PACK_BYTES = 16;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLoad,
    StWrite,
    StRun,
    StRbAddr,
    StRbWait,
    StRbSend
  } state_e;

  function automatic int unsigned bytes_per_word(int unsigned width);
    return width / 8;
  endfunction

  localparam int unsigned ACT_BPW   = bytes_per_word(8);
  localparam int unsigned PARAM_BPW = bytes_per_word(128);
  localparam int unsigned INST_BPW  = bytes_per_word(80);

endpackage

// File: rtl/byte_word_packer.sv
// Byte-to-word shift register: bytes enter at the LSB end so the first byte of a
// word lands in its MSB; flags the byte that completes a word of num_bytes_i bytes.
module byte_word_packer #(
  parameter int unsigned MaxBytes = 16,
  localparam int unsigned CntW = $clog2(MaxBytes + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  input  logic [CntW-1:0]       num_bytes_i,
  output logic [MaxBytes*8-1:0] word_o,
  output logic                  word_done_o
);

  logic [(MaxBytes-1)*8-1:0] shreg_q;
  logic [CntW-1:0]           cnt_q, cnt_d;

  // Word including the byte currently being accepted, so the consumer can
  // latch it on the same edge.
  assign word_o      = {shreg_q, byte_i};
  assign word_done_o = byte_valid_i && (cnt_q == num_bytes_i - CntW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (byte_valid_i) begin
      cnt_d = word_done_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clr_i) begin
        shreg_q <= '0;
      end else if (byte_valid_i) begin
        shreg_q <= word_o[(MaxBytes-1)*8-1:0];
      end
    end
  end

endmodule

// File: rtl/ext_mem_loader.sv
// Byte-stream loader for processor_top: parses command frames into external memory
// writes and run launches. Activation readback is built only with LOADER_READBACK_EN.
module ext_mem_loader
  import ext_mem_loader_pkg::*;
#(
  parameter int unsigned WIDTH_ACT_MEM    = 8,
  parameter int unsigned WIDTH_PARAM_MEM  = 128,
  parameter int unsigned WIDTH_INST_MEM   = 80,
  parameter int unsigned WIDTH_ADDR_ACT   = 12,
  parameter int unsigned WIDTH_ADDR_PARAM = 13,
  parameter int unsigned WIDTH_ADDR_INST  = 6,
  parameter int unsigned RD_LAT           = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        sel_ext,
  output logic                        en,
  input  logic                        done,
  output logic                        wea_actmem_ext,
  output logic                        wea_parammem_ext,
  output logic                        wea_instmem_ext,
  output logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext,
  output logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext,
  output logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext,
  output logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext,
  output logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext,
  output logic [WIDTH_INST_MEM-1:0]   instmem_in_ext,
  input  logic [WIDTH_ACT_MEM-1:0]    actmem_out,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        run_done,
  output logic                        err
);

  localparam int unsigned BpwW    = $clog2(PACK_BYTES + 1);
  localparam int unsigned HdrCntW = $clog2(HDR_BYTES);

  localparam logic [BpwW-1:0] ActBpw   = BpwW'(bytes_per_word(WIDTH_ACT_MEM));
  localparam logic [BpwW-1:0] ParamBpw = BpwW'(bytes_per_word(WIDTH_PARAM_MEM));
  localparam logic [BpwW-1:0] InstBpw  = BpwW'(bytes_per_word(WIDTH_INST_MEM));

  state_e               state_q, state_d;
  logic [2:0]           tgt_q, tgt_d;
  logic [HdrCntW-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [15:0]          addr_q, addr_d, addr_inc;
  logic [15:0]          len_q, len_d;

  logic                 in_ready_q, in_ready_d;
  logic                 sel_q, sel_d;
  logic                 en_q, en_d;
  logic                 run_done_q, run_done_d;
  logic                 err_q, err_d;
  logic                 wea_act_q, wea_act_d;
  logic                 wea_param_q, wea_param_d;
  logic                 wea_inst_q, wea_inst_d;

  logic [WIDTH_ADDR_ACT-1:0]   addr_act_q, addr_act_d;
  logic [WIDTH_ADDR_PARAM-1:0] addr_param_q, addr_param_d;
  logic [WIDTH_ADDR_INST-1:0]  addr_inst_q, addr_inst_d;
  logic [WIDTH_ACT_MEM-1:0]    act_data_q, act_data_d;
  logic [WIDTH_PARAM_MEM-1:0]  param_data_q, param_data_d;
  logic [WIDTH_INST_MEM-1:0]   inst_data_q, inst_data_d;

  logic                    accept;
  logic [BpwW-1:0]         num_bytes;
  logic [PACK_BYTES*8-1:0] pack_word;
  logic                    word_done;

`ifdef LOADER_READBACK_EN
  localparam int unsigned RdCntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
`endif

  assign accept   = in_valid && in_ready_q;
  assign addr_inc = addr_q + 16'd1;

  always_comb begin
    unique case (tgt_q)
      CMD_PARAM: num_bytes = ParamBpw;
      CMD_INST:  num_bytes = InstBpw;
      default:   num_bytes = ActBpw;
    endcase
  end

  byte_word_packer #(
    .MaxBytes (PACK_BYTES)
  ) u_packer (
    .clk_i        (clk),
    .rst_ni       (resetn),
    .clr_i        ((state_q == StIdle) || (state_q == StHdr)),
    .byte_valid_i (accept && (state_q == StLoad)),
    .byte_i       (in_data),
    .num_bytes_i  (num_bytes),
    .word_o       (pack_word),
    .word_done_o  (word_done)
  );

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    hdr_cnt_d    = hdr_cnt_q;
    addr_d       = addr_q;
    len_d        = len_q;
    wea_act_d    = 1'b0;
    wea_param_d  = 1'b0;
    wea_inst_d   = 1'b0;
    addr_act_d   = addr_act_q;
    addr_param_d = addr_param_q;
    addr_inst_d  = addr_inst_q;
    act_data_d   = act_data_q;
    param_data_d = param_data_q;
    inst_data_d  = inst_data_q;
    run_done_d   = 1'b0;
    err_d        = 1'b0;
`ifdef LOADER_READBACK_EN
    rd_cnt_d     = rd_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_data[7:3] != 5'd0) begin
            err_d = 1'b1;
          end else begin
            case (in_data[2:0])
              CMD_ACT, CMD_PARAM, CMD_INST: begin
                tgt_d     = in_data[2:0];
                hdr_cnt_d = '0;
                state_d   = StHdr;
              end
              CMD_START: state_d = StRun;
`ifdef LOADER_READBACK_EN
              CMD_RB: begin
                tgt_d     = CMD_RB;
                hdr_cnt_d = '0;
                state_d   = StHdr;
              end
`endif
              default: err_d = 1'b1;
            endcase
          end
        end
      end

      StHdr: begin
        if (accept) begin
          hdr_cnt_d = hdr_cnt_q + HdrCntW'(1);
          unique case (hdr_cnt_q)
            HdrCntW'(0): addr_d[15:8] = in_data;
            HdrCntW'(1): addr_d[7:0]  = in_data;
            HdrCntW'(2): len_d[15:8]  = in_data;
            default: begin
              len_d[7:0] = in_data;
              if ({len_q[15:8], in_data} == 16'd0) begin
                state_d = StIdle;
              end else if (tgt_q == CMD_RB) begin
                addr_act_d = addr_q[WIDTH_ADDR_ACT-1:0];
                state_d    = StRbAddr;
              end else begin
                state_d = StLoad;
              end
            end
          endcase
        end
      end

      StLoad: begin
        // Latch strobe, address and word together so the ports hold between writes.
        if (accept && word_done) begin
          state_d = StWrite;
          unique case (tgt_q)
            CMD_PARAM: begin
              wea_param_d  = 1'b1;
              addr_param_d = addr_q[WIDTH_ADDR_PARAM-1:0];
              param_data_d = pack_word[WIDTH_PARAM_MEM-1:0];
            end
            CMD_INST: begin
              wea_inst_d  = 1'b1;
              addr_inst_d = addr_q[WIDTH_ADDR_INST-1:0];
              inst_data_d = pack_word[WIDTH_INST_MEM-1:0];
            end
            default: begin
              wea_act_d  = 1'b1;
              addr_act_d = addr_q[WIDTH_ADDR_ACT-1:0];
              act_data_d = pack_word[WIDTH_ACT_MEM-1:0];
            end
          endcase
        end
      end

      StWrite: begin
        addr_d  = addr_inc;
        len_d   = len_q - 16'd1;
        state_d = (len_q == 16'd1) ? StIdle : StLoad;
      end

      StRun: begin
        if (done) begin
          run_done_d = 1'b1;
          state_d    = StIdle;
        end
      end

`ifdef LOADER_READBACK_EN
      StRbAddr: begin
        rd_cnt_d = '0;
        state_d  = StRbWait;
      end

      StRbWait: begin
        if (rd_cnt_q == RdCntW'(RD_LAT - 1)) begin
          out_data_d  = actmem_out[7:0];
          out_valid_d = 1'b1;
          state_d     = StRbSend;
        end else begin
          rd_cnt_d = rd_cnt_q + RdCntW'(1);
        end
      end

      StRbSend: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = addr_inc;
          addr_act_d  = addr_inc[WIDTH_ADDR_ACT-1:0];
          len_d       = len_q - 16'd1;
          state_d     = (len_q == 16'd1) ? StIdle : StRbAddr;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    // Handshake and run-control outputs are registered off the next state.
    in_ready_d = (state_d == StIdle) || (state_d == StHdr) || (state_d == StLoad);
    en_d       = (state_d == StRun);
    sel_d      = !en_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      tgt_q        <= CMD_ACT;
      hdr_cnt_q    <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      in_ready_q   <= 1'b0;
      sel_q        <= 1'b1;
      en_q         <= 1'b0;
      run_done_q   <= 1'b0;
      err_q        <= 1'b0;
      wea_act_q    <= 1'b0;
      wea_param_q  <= 1'b0;
      wea_inst_q   <= 1'b0;
      addr_act_q   <= '0;
      addr_param_q <= '0;
      addr_inst_q  <= '0;
      act_data_q   <= '0;
      param_data_q <= '0;
      inst_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      in_ready_q   <= in_ready_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      run_done_q   <= run_done_d;
      err_q        <= err_d;
      wea_act_q    <= wea_act_d;
      wea_param_q  <= wea_param_d;
      wea_inst_q   <= wea_inst_d;
      addr_act_q   <= addr_act_d;
      addr_param_q <= addr_param_d;
      addr_inst_q  <= addr_inst_d;
      act_data_q   <= act_data_d;
      param_data_q <= param_data_d;
      inst_data_q  <= inst_data_d;
    end
  end

`ifdef LOADER_READBACK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`else
  logic unused_rb;
  assign unused_rb = ^{actmem_out, out_ready, RD_LAT};
  assign out_valid = 1'b0;
  assign out_data  = 8'd0;
`endif

  assign in_ready          = in_ready_q;
  assign sel_ext           = sel_q;
  assign en                = en_q;
  assign run_done          = run_done_q;
  assign err               = err_q;
  assign wea_actmem_ext    = wea_act_q;
  assign wea_parammem_ext  = wea_param_q;
  assign wea_instmem_ext   = wea_inst_q;
  assign addr_actmem_ext   = addr_act_q;
  assign addr_parammem_ext = addr_param_q;
  assign addr_instmem_ext  = addr_inst_q;
  assign actmem_in_ext     = act_data_q;
  assign parammem_in_ext   = param_data_q;
  assign instmem_in_ext    = inst_data_q;

endmodule

// File: doc/ext_mem_loader.md
# ext_mem_loader

Host-side loader that sits directly upstream of `processor_top`. It takes a byte stream with a valid/ready handshake and drives the processor's external write ports (`sel_ext`, `wea_*_ext`, `addr_*_ext`, `*_in_ext`). It parses command frames that fill activation, parameter or instruction memory, and launches a run by handing memory control to the internal controller and holding `en` until `done`.

## Interface
Parameters:
- WIDTH_ACT_MEM, 8, activation word width (multiple of 8)
- WIDTH_PARAM_MEM, 128, parameter word width (multiple of 8)
- WIDTH_INST_MEM, 80, instruction word width (multiple of 8)
- WIDTH_ADDR_ACT, 12, activation address width
- WIDTH_ADDR_PARAM, 13, parameter address width
- WIDTH_ADDR_INST, 6, instruction address width
- RD_LAT, 1, activation-memory read latency in cycles (readback only)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  loader accepts the byte; a transfer happens when in_valid and in_ready are both high
- sel_ext  out  1  1 = external side owns the memories
- en  out  1  processor enable
- done  in  1  processor `done`
- wea_actmem_ext / wea_parammem_ext / wea_instmem_ext  out  1 each  one-cycle write strobes
- addr_actmem_ext / addr_parammem_ext / addr_instmem_ext  out  respective address width  write (or read) address
- actmem_in_ext / parammem_in_ext / instmem_in_ext  out  respective data width  write data
- actmem_out  in  WIDTH_ACT_MEM  activation read data (readback only)
- out_data  out  8, out_valid  out  1, out_ready  in  1  readback stream (readback only)
- run_done  out  1  one-cycle pulse when a run ends
- err  out  1  one-cycle pulse when an illegal command byte arrives

## Operation
- Frame layout: a command byte, then (for load and readback) ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then for load LEN words of payload.
- Command byte cmd[2:0]:
  - 0 = activation load
  - 1 = parameter load
  - 2 = instruction load
  - 3 = start
  - 4 = activation readback
  - cmd[7:3] must be 0.
- Illegal command byte: the byte is consumed, `err` pulses, and the FSM stays in IDLE.
- States: IDLE, HDR, LOAD, WRITE, RUN, RB_ADDR, RB_WAIT, RB_SEND.
  - IDLE: decodes the command byte. Load or readback → HDR. Start → RUN. The start command has no header.
  - HDR: accepts exactly 4 bytes. ADDR is 16 bits, truncated to the target's address width. LEN is the word count. If LEN = 0 → IDLE with no writes. Otherwise → LOAD, or RB_ADDR for readback.
  - LOAD: shifts each byte into a 128-bit register at the LSB end, so the first byte ends up as the word MSB.
    - Bytes per word = data width / 8: act 1, param 16, inst 10.
    - After the last byte of a word → WRITE.
  - WRITE: for exactly one cycle, raises the target's `wea` with the assembled word on the data port and the current address. The address then increments modulo 2^width (wrap-around is silent) and LEN decrements. Then → LOAD, or → IDLE when LEN reaches 0.
  - RUN: `sel_ext` = 0 and `en` = 1 from the cycle after the start byte is accepted. When `done` = 1 is sampled, `en` and `sel_ext` return to 0 and 1 on the next edge, `run_done` pulses, and the FSM goes to IDLE.
- `in_ready` is high only in IDLE, HDR and LOAD. It is low in WRITE, RUN and all RB_* states.
- Write strobes are mutually exclusive. Address and data ports hold their values when no strobe is active.
- Reset asserted mid-frame: the partial word and header are discarded and no strobe is issued. `en` drops asynchronously.

## Timing
- Reset values:
  - in_ready 0, going to 1 on the first rising edge after resetn deasserts
  - sel_ext 1
  - en 0
  - all wea 0
  - all addresses and data 0
  - out_valid 0, out_data 0
  - run_done 0, err 0
- Load latency: `wea` is high in the cycle after the last byte of a word is accepted. Throughput is one word per (bytes-per-word + 1) cycles.
- `err` is high in the cycle after the illegal byte is accepted.
- `done` is sampled only in RUN. A `done` held high on entry to RUN ends the run after 1 cycle of `en`.

## Configuration
- LOADER_READBACK_EN defined: command 4 is legal.
  - RB_ADDR drives `addr_actmem_ext` with `sel_ext` = 1.
  - RB_WAIT waits RD_LAT cycles and captures `actmem_out` into `out_data`.
  - RB_SEND holds `out_valid` until `out_ready`, then increments the address and decrements LEN. At LEN = 0 → IDLE.
- LOADER_READBACK_EN undefined: command 4 is illegal (`err` pulses). `out_valid` and `out_data` are tied to 0 and `actmem_out` / `out_ready` are ignored.

## Structure
- A shared package holds:
  - the command encodings (CMD_ACT, CMD_PARAM, CMD_INST, CMD_START, CMD_RB)
  - the state enum
  - the header byte count (4)
  - the bytes-per-word constants derived from the widths
- One sub-module: `byte_word_packer`. It is a shift register plus a byte counter, with configurable byte count, and produces a word-complete flag.

## Test plan
- Activation load: cmd 0x00, addr 0x0010, len 2, bytes 0xA5 0x5A → two `wea_actmem_ext` pulses: addr 0x010 with data 0xA5, then 0x011 with 0x5A. `in_ready` is low on both WRITE cycles.
- Instruction load: cmd 0x02, addr 0x003F, len 2, 20 bytes 0x01..0x14 → write 1 at addr 0x3F with data 0x0102…0A. Write 2 at addr 0x00 (wrap) with data 0x0B…14.
- Parameter load with len 0: cmd 0x01, addr 0x1234, len 0 → no strobe, FSM back in IDLE after 5 bytes. A subsequent cmd 0xFF → `err` pulses once.
- Start: cmd 0x03, `done` asserted 7 cycles later → `en` high for 7 cycles with `sel_ext` = 0, then `run_done` pulses and `sel_ext` returns to 1.
- Reset after 8 of 16 param bytes → no `wea_parammem_ext`. The next full frame writes correctly.
- Readback (macro defined): act memory preloaded with 0x11, 0x22; cmd 0x04, addr 0, len 2, `out_ready` stalled 3 cycles → out_data 0x11 then 0x22, each held until accepted. With the macro undefined, the same command → `err`.
